// File: rtl/dram_fifo_pkg.sv
// Shared types and defaults for the DRAM FIFO responder.
// DRAM_RESP_BYTE_MASK_EN adds a per-byte write mask field to the request word.
package dram_fifo_pkg;

  localparam int unsigned DEF_ADDR_W = 27;
  localparam int unsigned DEF_DATA_W = 128;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef struct packed {
    logic                    cmd;
    logic [DEF_ADDR_W-1:0]   addr;
`ifdef DRAM_RESP_BYTE_MASK_EN
    logic [DEF_DATA_W/8-1:0] wmask;
`endif
    logic [DEF_DATA_W-1:0]   wdata;
  } dram_req_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_WAIT,
    ST_ACCESS,
    ST_READ_DONE,
    ST_RESP
  } resp_state_t;

  // Width of a request word {cmd, addr, [wmask,] wdata} for arbitrary widths.
  function automatic int unsigned req_width(int unsigned addr_w, int unsigned data_w);
`ifdef DRAM_RESP_BYTE_MASK_EN
    return 1 + addr_w + data_w / 8 + data_w;
`else
    return 1 + addr_w + data_w;
`endif
  endfunction

endpackage

// File: rtl/dram_fifo_responder_if.sv
// Request/response FIFO pair seen from the CPU side (master) and the memory side (slave).
interface dram_fifo_responder_if
  import dram_fifo_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);
  localparam int unsigned REQ_W = req_width(ADDR_W, DATA_W);

  logic              req_fifo_empty;
  logic              req_fifo_rd_en;
  logic [REQ_W-1:0]  req_fifo_dout;
  logic              rsp_fifo_full;
  logic              rsp_fifo_wr_en;
  logic [DATA_W-1:0] rsp_fifo_din;

  modport master (
    output req_fifo_empty,
    output req_fifo_dout,
    output rsp_fifo_full,
    input  req_fifo_rd_en,
    input  rsp_fifo_wr_en,
    input  rsp_fifo_din
  );

  modport slave (
    input  req_fifo_empty,
    input  req_fifo_dout,
    input  rsp_fifo_full,
    output req_fifo_rd_en,
    output rsp_fifo_wr_en,
    output rsp_fifo_din
  );

endinterface

// File: rtl/dram_fifo_responder_line_ram.sv
// Single-port line store: synchronous read with one cycle of latency, byte-enabled write.
module dram_line_ram #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned DATA_W     = 128
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned b = 0; b < BE_W; b++) begin
          if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dram_fifo_responder.sv
// Memory-side responder for the DRAM request/response FIFOs, backed by a BRAM line store.
// DRAM_RESP_BYTE_MASK_EN enables masked (byte-enabled) line writes.
module dram_fifo_responder
  import dram_fifo_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 8
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  dram_fifo_responder_if.slave  fifo,
  output logic                  busy
);
  localparam int unsigned REQ_W = req_width(ADDR_W, DATA_W);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);

  resp_state_t           state;
  logic [CNT_W-1:0]      lat_cnt;
  logic                  cap_cmd;
  logic [DEPTH_LOG2-1:0] cap_idx;
  logic [DATA_W-1:0]     cap_wdata;
  logic [BE_W-1:0]       cap_wmask;
  logic [DATA_W-1:0]     rsp_data;

  logic                  req_cmd;
  logic [ADDR_W-1:0]     req_addr;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic [DATA_W-1:0]     req_wdata;
  logic [BE_W-1:0]       req_wmask;
  logic                  addr_unused;

  logic                  ram_en;
  logic                  ram_we;
  logic [DATA_W-1:0]     ram_rdata;

  assign req_cmd   = fifo.req_fifo_dout[REQ_W-1];
  assign req_addr  = fifo.req_fifo_dout[REQ_W-2 -: ADDR_W];
  assign req_wdata = fifo.req_fifo_dout[DATA_W-1:0];
`ifdef DRAM_RESP_BYTE_MASK_EN
  assign req_wmask = fifo.req_fifo_dout[DATA_W +: BE_W];
`else
  assign req_wmask = '1;
`endif

  // Line-aligned: offset bits and bits above the index alias onto the same line.
  assign req_idx     = req_addr[DEPTH_LOG2+3:4];
  assign addr_unused = ^{req_addr[ADDR_W-1:DEPTH_LOG2+4], req_addr[3:0]};

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      lat_cnt  <= '0;
      rsp_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo.req_fifo_empty) begin
            state <= ST_CAPTURE;
            busy  <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          cap_cmd   <= req_cmd;
          cap_idx   <= req_idx;
          cap_wdata <= req_wdata;
          cap_wmask <= req_wmask;
          lat_cnt   <= CNT_LOAD;
          state     <= (LATENCY > 0) ? ST_WAIT : ST_ACCESS;
        end
        ST_WAIT: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt == CNT_W'(1)) state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (cap_cmd == CMD_WRITE) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= ST_READ_DONE;
          end
        end
        ST_READ_DONE: begin
          rsp_data <= ram_rdata;
          state    <= ST_RESP;
        end
        ST_RESP: begin
          if (!fifo.rsp_fifo_full) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Strobes follow the live flags so a pop/push lands in the very cycle it is allowed;
  // gating with rst keeps a reset cycle from popping, pushing or writing.
  assign fifo.req_fifo_rd_en = !rst && (state == ST_IDLE) && !fifo.req_fifo_empty;
  assign fifo.rsp_fifo_wr_en = !rst && (state == ST_RESP) && !fifo.rsp_fifo_full;
  assign fifo.rsp_fifo_din   = rsp_data;

  assign ram_en = !rst && (state == ST_ACCESS);
  assign ram_we = ram_en && (cap_cmd == CMD_WRITE);

  dram_line_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_line_ram (
    .clk   (sys_clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (cap_wmask),
    .addr  (cap_idx),
    .wdata (cap_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_dram_fifo_responder.sv
// Randomized bench for dram_fifo_responder against an in-order line-memory model.
// Build with DRAM_RESP_BYTE_MASK_EN to exercise masked writes as well.
module tb_dram_fifo_responder;
  import dram_fifo_pkg::*;

  localparam int unsigned LAT    = 8;
  localparam int unsigned DLOG   = 12;
  localparam int unsigned BE_W   = DEF_DATA_W / 8;
  localparam int unsigned NLINES = 16;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  logic busy;

  int checks    = 0;
  int errors    = 0;
  int cycle     = 0;
  int rsp_count = 0;
  int rd_cycle  = 0;
  logic full_seen = 1'b0;
  logic rd_prev   = 1'b0;
  logic wr_prev   = 1'b0;
  logic stop_full = 1'b0;

  dram_req_t         req_q[$];
  logic [127:0]      exp_q[$];
  logic [127:0]      mem_model [int unsigned];

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cycle++;

  dram_fifo_responder_if #(.ADDR_W(DEF_ADDR_W), .DATA_W(DEF_DATA_W)) fifo ();

  dram_fifo_responder #(
    .ADDR_W     (DEF_ADDR_W),
    .DATA_W     (DEF_DATA_W),
    .DEPTH_LOG2 (DLOG),
    .LATENCY    (LAT)
  ) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .fifo    (fifo),
    .busy    (busy)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Model: a write updates the selected bytes of its line, a read yields the current line.
  task automatic push_req(input logic wr, input logic [26:0] addr, input logic [127:0] data,
                          input logic [BE_W-1:0] mask);
    dram_req_t    r;
    int unsigned  line;
    logic [127:0] cur;
    line = (32'(addr) >> 4) % (32'd1 << DLOG);
    r.cmd   = wr ? CMD_WRITE : CMD_READ;
    r.addr  = addr;
    r.wdata = data;
`ifdef DRAM_RESP_BYTE_MASK_EN
    r.wmask = mask;
`endif
    cur = mem_model.exists(line) ? mem_model[line] : '0;
    if (wr) begin
      for (int b = 0; b < int'(BE_W); b++) if (mask[b]) cur[b*8 +: 8] = data[b*8 +: 8];
      mem_model[line] = cur;
    end else begin
      exp_q.push_back(cur);
    end
    req_q.push_back(r);
  endtask

  task automatic push_raw_write(input logic [26:0] addr, input logic [127:0] data);
    dram_req_t r;
    r.cmd   = CMD_WRITE;
    r.addr  = addr;
    r.wdata = data;
`ifdef DRAM_RESP_BYTE_MASK_EN
    r.wmask = '1;
`endif
    req_q.push_back(r);
  endtask

  task automatic drain(input string tag);
    logic done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge sys_clk);
      done = (req_q.size() == 0) && !busy && !fifo.req_fifo_rd_en && (exp_q.size() == 0);
    end
    check(tag, done, 1'b1);
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic wait_pop(input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge sys_clk);
      seen = fifo.req_fifo_rd_en;
    end
    check(tag, seen, 1'b1);
  endtask

  // Standard (non-FWFT) request FIFO: a pop sampled at an edge presents data after it.
  initial begin
    logic pop_now;
    fifo.req_fifo_empty = 1'b1;
    fifo.req_fifo_dout  = '0;
    forever begin
      @(negedge sys_clk);
      pop_now = fifo.req_fifo_rd_en;
      @(posedge sys_clk);
      #1;
      if (pop_now) begin
        if (req_q.size() == 0) check("over_pop", pop_now, 1'b0);
        else fifo.req_fifo_dout = req_q.pop_front();
      end
      fifo.req_fifo_empty = (req_q.size() == 0);
    end
  end

  // Response-side monitor.
  always @(negedge sys_clk) begin
    if (!rst) begin
      if (fifo.req_fifo_rd_en) begin
        check("rd_single", rd_prev, 1'b0);
        check("rd_when_idle", busy, 1'b0);
        rd_cycle  = cycle;
        full_seen = 1'b0;
      end
      if (fifo.rsp_fifo_full && busy) full_seen = 1'b1;
      if (fifo.rsp_fifo_wr_en) begin
        check("wr_single", wr_prev, 1'b0);
        check("wr_vs_full", fifo.rsp_fifo_full, 1'b0);
        rsp_count++;
        if (exp_q.size() == 0) check("rsp_extra", fifo.rsp_fifo_wr_en, 1'b0);
        else check("rsp_data", fifo.rsp_fifo_din, exp_q.pop_front());
        if (!full_seen) check("rsp_latency", 128'(cycle - rd_cycle), 128'(LAT + 4));
      end
    end
    rd_prev = fifo.req_fifo_rd_en;
    wr_prev = fifo.rsp_fifo_wr_en;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] d1, old_val, held;
    int base, nreads;
    logic [26:0] a;
    logic [BE_W-1:0] m;

    fifo.rsp_fifo_full = 1'b0;
    d1      = 128'h0123456789ABCDEF0123456789ABCDEF;
    old_val = 128'h5555AAAA5555AAAA5555AAAA5555AAAA;

    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("reset_busy", busy, 1'b0);
    check("reset_rd_en", fifo.req_fifo_rd_en, 1'b0);
    check("reset_wr_en", fifo.rsp_fifo_wr_en, 1'b0);
    check("reset_din", fifo.rsp_fifo_din, '0);
    @(posedge sys_clk);
    #1 rst = 1'b0;

    // Write then read the same line: one response, none for the write.
    base = rsp_count;
    push_req(1'b1, 27'h0000040, d1, '1);
    push_req(1'b0, 27'h0000040, '0, '1);
    drain("t1_drain");
    check("t1_rsp_count", 128'(rsp_count - base), 128'd1);

    // Single read with free response FIFO; latency checked by the monitor.
    base = rsp_count;
    push_req(1'b0, 27'h7FF0048, '0, '1);
    drain("t2_drain");
    check("t2_rsp_count", 128'(rsp_count - base), 128'd1);

    // Four back-to-back reads with the request FIFO never empty.
    for (int i = 0; i < 4; i++) push_req(1'b1, 27'(32'h200 + 32'(i) * 16), rand128(), '1);
    drain("t3_init");
    base = rsp_count;
    for (int i = 0; i < 4; i++) push_req(1'b0, 27'(32'h200 + 32'(i) * 16), '0, '1);
    drain("t3_drain");
    check("t3_rsp_count", 128'(rsp_count - base), 128'd4);

    // Response FIFO held full for 20 cycles in RESP.
    fifo.rsp_fifo_full = 1'b1;
    push_req(1'b0, 27'h0000040, '0, '1);
    wait_pop("t4_pop");
    repeat (LAT + 4) @(negedge sys_clk);
    held = fifo.rsp_fifo_din;
    check("t4_hold_data", held, d1);
    push_req(1'b0, 27'h0000200, '0, '1);
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      check("t4_no_push", fifo.rsp_fifo_wr_en, 1'b0);
      check("t4_no_pop", fifo.req_fifo_rd_en, 1'b0);
      check("t4_stable", fifo.rsp_fifo_din, held);
    end
    @(posedge sys_clk);
    #1 fifo.rsp_fifo_full = 1'b0;
    @(negedge sys_clk);
    check("t4_release_push", fifo.rsp_fifo_wr_en, 1'b1);
    drain("t4_drain");

    // Reset during WAIT of a write: dropped, old contents survive.
    push_req(1'b1, 27'h0000100, old_val, '1);
    drain("t5_init");
    base = rsp_count;
    push_raw_write(27'h0000100, {16{8'hAA}});
    wait_pop("t5_pop");
    repeat (3) @(negedge sys_clk);
    rst = 1'b1;
    @(negedge sys_clk);
    check("t5_busy_after_rst", busy, 1'b0);
    rst = 1'b0;
    repeat (30) @(negedge sys_clk);
    check("t5_no_push", 128'(rsp_count - base), 128'd0);
    push_req(1'b0, 27'h0000100, '0, '1);
    drain("t5_drain");

`ifdef DRAM_RESP_BYTE_MASK_EN
    // Masked write touches only byte 0.
    push_req(1'b1, 27'h0000300, '1, '1);
    push_req(1'b1, 27'h0000300, '0, 16'h0001);
    push_req(1'b0, 27'h0000300, '0, '1);
    drain("t6_drain");
`endif

    // Randomized traffic over a small aliased line pool with a toggling full flag.
    for (int i = 0; i < int'(NLINES); i++) push_req(1'b1, 27'(32'h400 + 32'(i) * 16), rand128(), '1);
    drain("rand_init");
    base   = rsp_count;
    nreads = 0;
    fork
      begin
        while (!stop_full) begin
          @(posedge sys_clk);
          #1 fifo.rsp_fifo_full = ($urandom_range(0, 3) == 0);
        end
        fifo.rsp_fifo_full = 1'b0;
      end
      begin
        for (int n = 0; n < 200; n++) begin
          a = 27'($urandom);
          a[15:4] = 12'(32'h40 + $urandom_range(0, NLINES - 1));
`ifdef DRAM_RESP_BYTE_MASK_EN
          m = BE_W'($urandom);
`else
          m = '1;
`endif
          if ($urandom_range(0, 1) == 0) begin
            push_req(1'b0, a, '0, m);
            nreads++;
          end else begin
            push_req(1'b1, a, rand128(), m);
          end
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) @(negedge sys_clk);
          for (int w = 0; w < 500 && req_q.size() > 4; w++) @(negedge sys_clk);
        end
        drain("rand_drain");
        stop_full = 1'b1;
      end
    join
    check("rand_rsp_count", 128'(rsp_count - base), 128'(nreads));

    repeat (5) @(negedge sys_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
